// File: rtl/multi_ramp_pkg.sv
// Shared definitions for the multi-channel test-pattern generator:
// mode encodings, LFSR tap table and a constant-safe clog2.
package multi_ramp_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } modeT;

  // Right-shifting Galois masks for maximal-length sequences.
  function automatic logic [15:0] lfsrTaps(input int width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ramp_channel.sv
// One pattern channel: holds the sample value and triangle direction, and
// exposes the post-tick value so the serializer can snapshot it on the tick edge.
module ramp_channel
  import multi_ramp_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int K      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] step,
  output logic [DATA_W-1:0] nextValue
);

  localparam logic [DATA_W-1:0] MAX_V  = '1;
  localparam logic [DATA_W-1:0] INIT_V = DATA_W'(K);
  localparam logic [DATA_W-1:0] SEED_V = DATA_W'(K + 1);
  localparam logic [DATA_W-1:0] TAPS   = DATA_W'(lfsrTaps(DATA_W));

  logic [DATA_W-1:0] value;
  logic [DATA_W-1:0] seed;
  logic [DATA_W:0]   upSum;
  logic              dirDown;
  logic              nextDirDown;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    nextValue   = value;
    nextDirDown = 1'b0;
    upSum       = {1'b0, value} + {1'b0, step};
    seed        = (value == '0) ? SEED_V : value;
    case (modeT'(mode))
      MODE_RAMP:  nextValue = upSum[DATA_W-1:0];
      MODE_TRI: begin
        if (!dirDown) begin
          if (upSum > {1'b0, MAX_V}) begin
            nextValue   = MAX_V;
            nextDirDown = 1'b1;
          end else begin
            nextValue = upSum[DATA_W-1:0];
          end
        end else if (value < step) begin
          nextValue = '0;
        end else begin
          nextValue   = value - step;
          nextDirDown = 1'b1;
        end
      end
      MODE_LFSR:  nextValue = (seed >> 1) ^ (seed[0] ? TAPS : '0);
      MODE_CONST: nextValue = step;
      default:    nextValue = value;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value   <= INIT_V;
      dirDown <= 1'b0;
    end else if (tick) begin
      value   <= nextValue;
      dirDown <= nextDirDown;
    end
  end

endmodule

// File: rtl/multi_ramp_gen.sv
// N_CH-channel test-pattern source with an internal sample-tick divider and a
// valid/ready serializer that emits one tagged word per masked channel per tick.
module multi_ramp_gen
  import multi_ramp_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int N_CH   = 4,
  parameter int OUT_W  = 16,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] step,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              sample_ready,
  output logic              sample_valid,
  output logic [OUT_W-1:0]  sample_data,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int CHW = (clog2(N_CH) > 1) ? clog2(N_CH) : 1;
  localparam int DCW = (clog2(DIV) > 1) ? clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

  if (CHW + DATA_W > OUT_W) begin : gBadWidth
    $error("multi_ramp_gen: OUT_W cannot hold channel id plus sample value");
  end
  if (N_CH < 1 || DIV < 1) begin : gBadParam
    $error("multi_ramp_gen: N_CH and DIV must be at least 1");
  end

  typedef enum logic {IDLE, SEND} stateT;

  logic [DCW-1:0]    divCnt;
  logic              tick;
  logic [DATA_W-1:0] chNext [N_CH];
  logic [DATA_W-1:0] shadow [N_CH];
  stateT             state, nextState;
  logic [N_CH-1:0]   pending, curBit;
  logic [CHW-1:0]    curCh;
  logic              accept, lastAccept, snapshot;

  assign tick = enable && (divCnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                divCnt <= '0;
    else if (!enable || tick)  divCnt <= '0;
    else                       divCnt <= divCnt + DCW'(1);
  end

  for (genvar k = 0; k < N_CH; k++) begin : gCh
    ramp_channel #(.DATA_W(DATA_W), .K(k)) uChan (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .mode     (mode),
      .step     (step),
      .nextValue(chNext[k])
    );
  end

  // Lowest pending channel is the one on the bus.
  assign curBit = pending & (~pending + N_CH'(1));

  always_comb begin
    curCh = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) curCh = CHW'(i);
    end
  end

  assign sample_valid = (state == SEND);
  assign accept       = sample_valid && sample_ready;
  assign lastAccept   = accept && ((pending & ~curBit) == '0);
  // A tick coinciding with the final accept starts the next frame without loss.
  assign snapshot     = tick && (ch_mask != '0) && ((state == IDLE) || lastAccept);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (snapshot) nextState = SEND;
      SEND:    if (lastAccept && !snapshot) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (snapshot)    pending <= ch_mask;
      else if (accept) pending <= pending & ~curBit;
      if (lastAccept)  frame_cnt <= frame_cnt + 16'd1;
      if (tick && (state == SEND) && !lastAccept) overflow <= 1'b1;
    end
  end

  // NOTE: shadow is deliberately left unreset; sample_data is gated by sample_valid, so stale contents never reach the port.
  always_ff @(posedge clk) begin
    if (snapshot) begin
      for (int k = 0; k < N_CH; k++) shadow[k] <= chNext[k];
    end
  end

  always_comb begin
    sample_data = '0;
    if (sample_valid) begin
      sample_data[OUT_W-1 -: CHW]  = curCh;
      sample_data[DATA_W-1:0]      = shadow[curCh];
    end
  end

endmodule

// File: tb/tb_multi_ramp_gen.sv
// Directed bench for multi_ramp_gen: reset, ramp frames, wrap, backpressure,
// triangle, masking, LFSR step and asynchronous reset mid-frame.
module tb_multi_ramp_gen;
  import multi_ramp_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, sample_ready;
  logic [1:0]  mode;
  logic [6:0]  step;
  logic [3:0]  ch_mask;
  logic        sample_valid, overflow;
  logic [15:0] sample_data, frame_cnt;

  int compared   = 0;
  int mismatched = 0;

  multi_ramp_gen #(.DATA_W(7), .N_CH(4), .OUT_W(16), .DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .step        (step),
    .ch_mask     (ch_mask),
    .sample_ready(sample_ready),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .overflow    (overflow),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (sample_valid !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 32'(sample_valid), 32'd1);
  endtask

  task automatic frameTick(input string tag);
    enable = 1'b1;
    @(negedge clk);
    waitValid(tag);
    enable = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sample_valid !== 1'b0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, " drained"}, 32'(sample_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] frameA [4];
    logic [15:0] frameB [3];
    logic [6:0]  triExp [7];
    logic        seen;
    frameA = '{16'h0001, 16'h4002, 16'h8003, 16'hC004};
    frameB = '{16'h4003, 16'h8004, 16'hC005};
    triExp = '{7'd50, 7'd100, 7'd127, 7'd77, 7'd27, 7'd0, 7'd50};

    reset = 1'b0; enable = 1'b0; mode = MODE_RAMP; step = 7'd1;
    ch_mask = 4'hF; sample_ready = 1'b1;
    @(negedge clk);
    check("rst valid",  32'(sample_valid), 32'd0);
    check("rst data",   32'(sample_data),  32'd0);
    check("rst ovf",    32'(overflow),     32'd0);
    check("rst frames", 32'(frame_cnt),    32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Ramp, first frame after DIV cycles, then a back-to-back second frame.
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("s1 no early word", 32'(sample_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s1 valid", 32'(sample_valid), 32'd1);
      check("s1 word",  32'(sample_data),  32'(frameA[i]));
    end
    @(negedge clk);
    check("s1 frames",     32'(frame_cnt),   32'd1);
    check("s1 next frame", 32'(sample_data), 32'h0002);
    check("s1 no ovf",     32'(overflow),    32'd0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s1 frame2 word", 32'(sample_data), 32'(frameB[i]));
    end
    @(negedge clk);
    check("s1 idle",    32'(sample_valid), 32'd0);
    check("s1 frames2", 32'(frame_cnt),    32'd2);

    // Ramp wrap-around.
    mode = MODE_CONST; step = 7'd126;
    frameTick("s2 c126");
    check("s2 const126", 32'(sample_data), 32'h007E);
    drain("s2 c126");
    mode = MODE_RAMP; step = 7'd3;
    frameTick("s2 wrap3");
    check("s2 126+3", 32'(sample_data), 32'h0001);
    drain("s2 wrap3");
    mode = MODE_CONST; step = 7'd127;
    frameTick("s2 c127");
    drain("s2 c127");
    mode = MODE_RAMP; step = 7'd1;
    frameTick("s2 wrap1");
    check("s2 127+1", 32'(sample_data), 32'h0000);
    @(negedge clk);
    check("s2 ch1 127+1", 32'(sample_data), 32'h4000);
    drain("s2 wrap1");

    // Triangle from 0 with step 50.
    mode = MODE_TRI; step = 7'd50;
    for (int i = 0; i < 7; i++) begin
      frameTick("s4 tri");
      check("s4 tri value", 32'(sample_data), 32'(triExp[i]));
      drain("s4 tri");
    end

    // Channel masking.
    mode = MODE_RAMP; step = 7'd1; ch_mask = 4'b0101;
    frameTick("s5 mask");
    check("s5 ch0", 32'(sample_data), 32'h0033);
    @(negedge clk);
    check("s5 ch2", 32'(sample_data), 32'h8033);
    @(negedge clk);
    check("s5 end", 32'(sample_valid), 32'd0);
    check("s5 frames", 32'(frame_cnt), 32'd14);
    ch_mask = 4'h0; enable = 1'b1; seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    enable = 1'b0;
    check("s5 mask0 silent", 32'(seen),      32'd0);
    check("s5 mask0 frames", 32'(frame_cnt), 32'd14);

    // LFSR step from 54.
    ch_mask = 4'hF; mode = MODE_LFSR;
    frameTick("lfsr");
    check("lfsr ch0", 32'(sample_data), 32'h001B);
    @(negedge clk);
    check("lfsr ch1", 32'(sample_data), 32'h401B);
    drain("lfsr");

    // Backpressure with a lost tick.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; mode = MODE_RAMP; step = 7'd1;
    @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("s3 first", 32'(sample_data), 32'h0001);
    sample_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("s3 held", 32'(sample_data), 32'h0001);
      if (i == 3) check("s3 ovf before tick", 32'(overflow), 32'd0);
      if (i == 4) check("s3 ovf after tick",  32'(overflow), 32'd1);
    end
    sample_ready = 1'b1; enable = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("s3 resume", 32'(sample_data), 32'(frameA[i]));
    end
    @(negedge clk);
    check("s3 idle",   32'(sample_valid), 32'd0);
    check("s3 frames", 32'(frame_cnt),    32'd1);
    check("s3 sticky", 32'(overflow),     32'd1);

    // Asynchronous reset while a word is held.
    enable = 1'b1;
    waitValid("s6 pre");
    sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("s6 valid", 32'(sample_valid), 32'd0);
    check("s6 data",  32'(sample_data),  32'd0);
    check("s6 ovf",   32'(overflow),     32'd0);
    check("s6 frame", 32'(frame_cnt),    32'd0);
    @(negedge clk);
    reset = 1'b1; sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("s6 no early word", 32'(sample_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s6 word", 32'(sample_data), 32'(frameA[i]));
    end
    enable = 1'b0;
    @(negedge clk);
    check("s6 frames", 32'(frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_ramp_gen.md
Name: multi_ramp_gen

Overview:
- Parametrised successor to the single-channel 7-bit ramp source that feeds the continuous-transfer FIFO and pipe-out path.
- Generates N_CH independent test-pattern channels on an internal sample tick. Modes: ramp, triangle, LFSR, constant.
- Serialises each tick's snapshot into tagged OUT_W-bit words over a valid/ready interface. The consumer is the transfer FIFO write side.
- Replaces the separate clock divider with an internal clock-enable, so the block runs in the same single clock domain as its consumer.

Parameters:
- DATA_W, 7: sample value width.
- N_CH, 4: channel count (at least 1).
- OUT_W, 16: output word width. Elaboration error unless CHW+DATA_W <= OUT_W, where CHW = max(1, clog2(N_CH)).
- DIV, 4: clocks per sample tick (at least 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  runs the tick counter.
- mode  in  2  0 RAMP, 1 TRIANGLE, 2 LFSR, 3 CONST.
- step  in  DATA_W  increment for RAMP/TRIANGLE; value for CONST.
- ch_mask  in  N_CH  channels emitted per frame.
- sample_ready  in  1  consumer accepts a word.
- sample_valid  out  1  word available.
- sample_data  out  OUT_W  bits [OUT_W-1 -: CHW] hold the channel id; bits [DATA_W-1:0] hold the value; all other bits are 0.
- overflow  out  1  sticky; set when a tick is lost. Cleared only by reset.
- frame_cnt  out  16  count of completed frames; wraps.

Behaviour:
Reset (reset=0, asynchronous):
- All outputs 0.
- div_cnt=0, serializer IDLE.
- Channel k value = k mod 2^DATA_W; triangle direction = up.

Tick generation:
- div_cnt counts 0..DIV-1 while enable=1.
- tick=1 in the cycle div_cnt==DIV-1.
- enable=0 holds div_cnt at 0. The first tick comes DIV cycles after enable rises.

Channel update on tick (all channels, regardless of ch_mask):
- RAMP: v = (v+step) mod 2^DATA_W.
- TRIANGLE, going up: if v+step > MAX then v=MAX and dir=down, else v+=step.
- TRIANGLE, going down: if v < step then v=0 and dir=up, else v-=step.
- LFSR: Galois shift using the taps for DATA_W. A zero state is forced to k+1 before shifting.
- CONST: v = step.
- Whenever mode != TRIANGLE, dir is set to up.
- A mode change applies from the next tick.

Serializer states: IDLE and SEND.
- IDLE + tick + ch_mask!=0:
  - Next cycle, the updated values are snapshotted into shadow registers and pending=ch_mask.
  - State becomes SEND.
  - sample_valid rises for the lowest pending channel.
  - Latency: tick cycle T gives the first word at T+1.
- SEND: on each valid&ready, clear that pending bit and present the next higher channel in the following cycle.
  - There are no bubbles while ready=1, so one frame is popcount(ch_mask) consecutive words.
- Last word accepted: frame_cnt+1, state IDLE, sample_valid=0 in the next cycle unless a new snapshot loads.
- Tick in the cycle the last word is accepted: the new snapshot is taken normally and there is no overflow.
- While valid&!ready, sample_data is held stable.
- tick while SEND (other than on the last accept):
  - overflow=1 and that snapshot is discarded.
  - Channel values still advance.
  - The in-flight frame continues unchanged.
- ch_mask=0 at tick: values advance, no words, frame_cnt unchanged.
- ch_mask is sampled only at snapshot; changes mid-frame are ignored.
- enable falling mid-frame: the current frame completes and no further ticks occur.
- Reset mid-frame: outputs 0 immediately. No remnant of the frame appears after release.

Decomposition:
- Package multi_ramp_pkg holds:
  - mode encodings (MODE_RAMP=0, MODE_TRI=1, MODE_LFSR=2, MODE_CONST=3);
  - a function returning the LFSR tap mask for DATA_W 4..16;
  - a clog2 function.
- Sub-module ramp_channel (one per channel, generate loop). Inputs: tick, mode, step, and channel index k as a parameter. Holds v and dir.
- The serializer/FSM and tick counter live in the top module.

Test Plan:
1. Defaults, mode=0, step=1, mask=4'hF, ready=1, enable rises.
   - First tick at cycle 4.
   - Words on consecutive cycles: 0x0001, 0x4002, 0x8003, 0xC004.
   - frame_cnt=1.
2. RAMP wrap: ch0 at 126 with step=3 gives next word 0x0001; with step=1 from 127 it gives 0x0000.
3. Backpressure: ready=0 for 10 cycles after the first valid.
   - sample_data stays 0x0001.
   - overflow=1 after the next tick.
   - Once ready=1, the frame completes in order 0x0001..0xC004 and frame_cnt=1.
4. TRIANGLE, step=50, ch0 from 0: values 50, 100, 127, 77, 27, 0, 50.
5. mask=4'b0101: each frame emits only ch0 then ch2 (id bits 00, 10). mask=0: sample_valid never rises and frame_cnt stays constant.
6. reset=0 asynchronously while a word is held with ready=0.
   - All outputs 0 in the same cycle.
   - After release with enable=1, the first frame again equals scenario 1.
